instruction_fetch_stage: RTL and testbench

Instruction fetch stage of the 5-stage pipeline. It holds the program counter, owns a word-addressed instruction memory that the bench can load, and produces the `pc` / `instruction` pair that the IF/ID register captures every cycle. It supports a freeze (stall) input from hazard detection and a branch redirect input from the execute stage.

---
 rtl/instruction_fetch_stage.sv | 57 +++++
 tb/tb_instruction_fetch_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC register, loadable instruction memory and fetch outputs
module instruction_fetch_stage #(
  parameter int LEN        = 32,
  parameter int IMEM_DEPTH = 256
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           freeze,
  input  logic           branch_taken,
  input  logic [LEN-1:0] branch_address,
  input  logic           imem_we,
  input  logic [LEN-1:0] imem_waddr,
  input  logic [LEN-1:0] imem_wdata,
  output logic [LEN-1:0] instruction,
  output logic [LEN-1:0] pc,
  output logic [LEN-1:0] fetch_pc
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [LEN-1:0] MEM_BYTES = LEN'(4 * IMEM_DEPTH);
  localparam logic [LEN-1:0] WORD_MASK = ~LEN'(3);

  logic [LEN-1:0] pc_q;
  logic [LEN-1:0] mem [IMEM_DEPTH];
  logic [AW-1:0]  fetch_idx;
  logic [AW-1:0]  write_idx;
  logic           fetch_in_range;
  logic           write_in_range;

  // Branch wins over freeze so a redirect is never lost behind a stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else if (branch_taken) begin
      pc_q <= branch_address & WORD_MASK;
    end else if (!freeze) begin
      pc_q <= pc_q + LEN'(4);
    end
  end

  assign fetch_idx      = pc_q[AW+1:2];
  assign write_idx      = imem_waddr[AW+1:2];
  assign fetch_in_range = (pc_q < MEM_BYTES);
  assign write_in_range = (imem_waddr < MEM_BYTES);

  // Program memory is deliberately outside the reset domain so a load survives reset.
  always_ff @(posedge clock) begin
    if (imem_we && write_in_range) begin
      mem[write_idx] <= imem_wdata;
    end
  end

  assign instruction = fetch_in_range ? mem[fetch_idx] : '0;
  assign pc          = pc_q + LEN'(4);
  assign fetch_pc    = pc_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed self-checking bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] fetch_pc;

  int total = 0;
  int bad   = 0;

  logic [31:0] load_addr [6];
  logic [31:0] load_data [6];

  instruction_fetch_stage #(.LEN(32), .IMEM_DEPTH(256)) dut (
    .clock          (clock),
    .reset          (reset),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .instruction    (instruction),
    .pc             (pc),
    .fetch_pc       (fetch_pc)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_is(input string tag, input logic [31:0] fpc, input logic [31:0] ins);
    check({tag, ".fetch_pc"}, fetch_pc, fpc);
    check({tag, ".pc"}, pc, fpc + 32'd4);
    check({tag, ".instr"}, instruction, ins);
  endtask

  initial begin
    load_addr[0] = 32'h0;   load_data[0] = 32'hA0;
    load_addr[1] = 32'h4;   load_data[1] = 32'hA1;
    load_addr[2] = 32'h8;   load_data[2] = 32'hA2;
    load_addr[3] = 32'hC;   load_data[3] = 32'hA3;
    load_addr[4] = 32'h10;  load_data[4] = 32'hB4;
    load_addr[5] = 32'h3FC; load_data[5] = 32'hFF;

    reset = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    #1;
    check("reset.fetch_pc", fetch_pc, 32'h0);
    check("reset.pc", pc, 32'h4);

    // program load while reset is held
    for (int i = 0; i < 6; i++) begin
      imem_we = 1'b1; imem_waddr = load_addr[i]; imem_wdata = load_data[i];
      step();
    end
    imem_we = 1'b0;
    fetch_is("reset_hold", 32'h0, 32'hA0);

    // sequential fetch
    reset = 1'b0;
    fetch_is("seq0", 32'h0, 32'hA0);
    step(); fetch_is("seq1", 32'h4, 32'hA1);
    step(); fetch_is("seq2", 32'h8, 32'hA2);

    // freeze for three cycles at 8
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); fetch_is("freeze", 32'h8, 32'hA2);
    end
    freeze = 1'b0;
    step(); fetch_is("unfreeze", 32'hC, 32'hA3);

    // branch overrides freeze, low address bits dropped
    freeze = 1'b1; branch_taken = 1'b1; branch_address = 32'h43;
    step();
    check("brfrz.fetch_pc", fetch_pc, 32'h40);
    check("brfrz.pc", pc, 32'h44);

    // last in-range word and first out-of-range address
    branch_address = 32'h3FC;
    step(); fetch_is("top_word", 32'h3FC, 32'hFF);
    branch_address = 32'h400;
    step(); fetch_is("oob", 32'h400, 32'h0);

    // PC wrap
    branch_address = 32'hFFFF_FFFC;
    step();
    check("wrap.fetch_pc", fetch_pc, 32'hFFFF_FFFC);
    check("wrap.pc", pc, 32'h0);
    check("wrap.instr", instruction, 32'h0);
    branch_taken = 1'b0; freeze = 1'b0;
    step(); fetch_is("wrapped", 32'h0, 32'hA0);

    // write/fetch collision while frozen at 0x10
    branch_taken = 1'b1; branch_address = 32'h10; freeze = 1'b1;
    step(); fetch_is("coll_pre", 32'h10, 32'hB4);
    branch_taken = 1'b0;
    imem_we = 1'b1; imem_waddr = 32'h10; imem_wdata = 32'hBEEF;
    #2;
    check("coll.before_edge", instruction, 32'hB4);
    step(); fetch_is("coll.after_edge", 32'h10, 32'hBEEF);
    imem_waddr = 32'h800; imem_wdata = 32'hDEAD;
    step(); check("oob_write.word4", instruction, 32'hBEEF);
    imem_waddr = 32'h13; imem_wdata = 32'hC0DE;
    step(); check("lowbits_write", instruction, 32'hC0DE);
    imem_we = 1'b0; freeze = 1'b0;

    // asynchronous reset mid-cycle at 0x20
    branch_taken = 1'b1; branch_address = 32'h20;
    step(); check("pre_rst.fetch_pc", fetch_pc, 32'h20);
    branch_taken = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    fetch_is("async_rst", 32'h0, 32'hA0);
    branch_taken = 1'b1; branch_address = 32'h80; freeze = 1'b0;
    step(); check("rst_ignores_branch", fetch_pc, 32'h0);
    branch_taken = 1'b0;
    #2;
    reset = 1'b0;
    step(); fetch_is("post_rst", 32'h4, 32'hA1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
